lut_burst_accum: RTL and testbench

LUT_BURST_ACCUM -- requirements
Module: lut_burst_accum

---
 rtl/lut_pkg.sv | 18 +
 rtl/lut_requant_clamp.sv | 42 ++++
 rtl/lut_burst_accum.sv | 134 +++++++++++++
 tb/tb_lut_burst_accum.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_pkg.sv
// Shared definitions for the LUT burst accumulator.
// Holds the default lane/beat counts, the pixel and LUT-value element types,
// and the accumulator state encoding.
package lut_pkg;

  localparam int LANES_DEFAULT = 16;
  localparam int BEATS_DEFAULT = 16;

  typedef logic        [7:0] pix_t;      // output pixel, unsigned
  typedef logic signed [7:0] lut_val_t;  // LUT row entry, signed

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } accum_state_t;

endpackage

// File: rtl/lut_requant_clamp.sv
// Per-lane requantiser: rounds the accumulated sum, arithmetic-shifts it
// right by SHIFT, adds the base pixel and clamps the result to [0,255].
// Purely combinational.
// Ports:
//   acc  - signed accumulated LUT sum (ACC_W bits)
//   base - unsigned source pixel
//   pix  - clamped output pixel
module lut_requant_clamp
  import lut_pkg::*;
#(
  parameter int ACC_W = 13,
  parameter int SHIFT = 2
) (
  input  logic signed [ACC_W-1:0] acc,
  input  pix_t                    base,
  output pix_t                    pix
);

  // Working width: at least 11 bits; two bits of headroom over the
  // accumulator so the rounding addend and base can never wrap.
  localparam int W = (ACC_W + 2 > 11) ? ACC_W + 2 : 11;
  // Half an LSB of the shifted result (zero when no shift is applied).
  localparam logic signed [W-1:0] ROUND = W'((2 ** SHIFT) / 2);

  logic signed [W-1:0] acc_ext;
  logic signed [W-1:0] shifted;
  logic signed [W-1:0] total;

  assign acc_ext = W'(acc);
  assign shifted = (acc_ext + ROUND) >>> SHIFT;
  assign total   = shifted + $signed({{(W-8){1'b0}}, base});

  always_comb begin
    pix = total[7:0];
    if (total[W-1]) begin
      pix = 8'd0;
    end else if (total > W'(255)) begin
      pix = 8'd255;
    end
  end

endmodule

// File: rtl/lut_burst_accum.sv
// LUT burst accumulator: sums LANES signed LUT values per beat over a block
// of up to BEATS beats, then requantises each lane sum against the base
// pixel captured on the first beat and holds the resulting pixel block until
// the consumer accepts it.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - beat handshake
//   in_data             - LANES signed 8-bit LUT values (lane i at [8i+7:8i])
//   in_last             - final beat of the block
//   base_pix            - source pixel, sampled on the first beat only
//   out_valid/out_ready - result handshake
//   out_pix             - LANES unsigned 8-bit output pixels
//   err_len             - one-cycle pulse when the block length is wrong
module lut_burst_accum
  import lut_pkg::*;
#(
  parameter int LANES = LANES_DEFAULT,
  parameter int BEATS = BEATS_DEFAULT,
  parameter int SHIFT = 2,
  parameter int ACC_W = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*8-1:0] in_data,
  input  logic               in_last,
  input  pix_t               base_pix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*8-1:0] out_pix,
  output logic               err_len
);

  localparam int CNT_W = $clog2(BEATS + 1);

  accum_state_t            state;
  logic [CNT_W-1:0]        beat_cnt;
  logic signed [ACC_W-1:0] acc [LANES];
  pix_t                    base;

  logic                    accept;
  logic                    first_beat;
  logic [CNT_W-1:0]        cnt_new;
  logic                    hit_max;
  logic                    close_blk;
  logic                    bad_len;
  pix_t                    base_sel;
  logic signed [ACC_W-1:0] acc_sum [LANES];
  logic [LANES*8-1:0]      pix_new;

  assign in_ready   = (state != ST_HOLD);
  assign accept     = in_valid && in_ready;
  assign first_beat = (state == ST_IDLE);

  // Count including the beat currently being accepted.
  assign cnt_new    = first_beat ? CNT_W'(1) : beat_cnt + CNT_W'(1);
  assign hit_max    = (cnt_new == CNT_W'(BEATS));
  assign close_blk  = accept && (in_last || hit_max);
  // Length is only correct when the last flag lands exactly on beat BEATS.
  assign bad_len    = accept && (in_last != hit_max);

  // The first beat's base is not registered yet, so use it directly when a
  // single-beat block closes out of IDLE.
  assign base_sel   = first_beat ? base_pix : base;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    lut_val_t lane_val;

    assign lane_val    = in_data[gi*8 +: 8];
    assign acc_sum[gi] = first_beat ? ACC_W'(lane_val)
                                    : acc[gi] + ACC_W'(lane_val);

    lut_requant_clamp #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
    ) u_requant (
      .acc  (acc_sum[gi]),
      .base (base_sel),
      .pix  (pix_new[gi*8 +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      base      <= '0;
      out_pix   <= '0;
      out_valid <= 1'b0;
      err_len   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc[i] <= '0;
      end
    end else begin
      err_len <= bad_len;

      unique case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            beat_cnt <= cnt_new;
            if (first_beat) begin
              base <= base_pix;
            end
            for (int i = 0; i < LANES; i++) begin
              acc[i] <= acc_sum[i];
            end
            if (close_blk) begin
              out_pix   <= pix_new;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end

        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            beat_cnt  <= '0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_burst_accum.sv
// Self-checking bench for lut_burst_accum: a driver issues blocks of beats and
// pushes the expected result into a scoreboard; an independent monitor pops
// and compares whenever a new result block appears.
module tb_lut_burst_accum;

  localparam int LANES = 16;
  localparam int BEATS = 16;
  localparam int SHIFT = 2;
  localparam int ACC_W = 13;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [LANES*8-1:0] in_data = '0;
  logic               in_last = 1'b0;
  logic [7:0]         base_pix = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [LANES*8-1:0] out_pix;
  logic               err_len;

  always #5 clk = ~clk;

  lut_burst_accum #(
    .LANES (LANES),
    .BEATS (BEATS),
    .SHIFT (SHIFT),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .base_pix  (base_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .err_len   (err_len)
  );

  typedef struct {
    logic [LANES*8-1:0] pix;
    logic               err;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ready_mode = 2;  // 0 random, 1 held low, 2 held high
  int   blk [BEATS][LANES];
  int   exp_over [LANES];
  int   n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LANES*8-1:0] act,
                     input logic [LANES*8-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, required DUT response", name);
  endtask

  // Reference: floor((sum + d/2) / d) + base, clamped to a byte.
  function automatic logic [7:0] ref_pix(input int sum, input int base);
    int d, t, q, v;
    d = 1 << SHIFT;
    t = sum + d / 2;
    q = (t >= 0) ? t / d : -((-t + d - 1) / d);
    v = base + q;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v[7:0];
  endfunction

  task automatic rand_inputs();
    for (int l = 0; l < LANES; l++) in_data[l*8 +: 8] = 8'($urandom_range(0, 255));
    in_last  = 1'($urandom_range(0, 1));
    base_pix = 8'($urandom_range(0, 255));
  endtask

  // Sends beats 0..len-1 of blk. A block that closes (last flag or BEATS
  // beats) pushes its expected result; a partial block pushes nothing.
  task automatic send_block(input int len, input bit last_fin, input int base,
                            input bit gaps, input bit use_over);
    int   sum [LANES];
    exp_t e;
    int   waitc;
    int   acc_cyc;
    for (int l = 0; l < LANES; l++) sum[l] = 0;
    acc_cyc = 0;
    for (int b = 0; b < len; b++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          rand_inputs();
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_last  = (b == len - 1) && last_fin;
      base_pix = (b == 0) ? 8'(base) : 8'($urandom_range(0, 255));
      for (int l = 0; l < LANES; l++) begin
        in_data[l*8 +: 8] = 8'(blk[b][l]);
        sum[l] += blk[b][l];
      end
      waitc = 0;
      @(negedge clk);
      while (!in_ready) begin
        waitc++;
        if (waitc > 300) begin
          fail_now("in_ready_wait");
          in_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      acc_cyc = cyc;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (last_fin || len == BEATS) begin
      for (int l = 0; l < LANES; l++)
        e.pix[l*8 +: 8] = use_over ? 8'(exp_over[l]) : ref_pix(sum[l], base);
      e.err = !(len == BEATS && last_fin);
      e.cyc = acc_cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic fill(input int v);
    for (int b = 0; b < BEATS; b++)
      for (int l = 0; l < LANES; l++) blk[b][l] = v;
  endtask

  task automatic set_over(input int v);
    for (int l = 0; l < LANES; l++) exp_over[l] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_out_pix", out_pix, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid) begin
      n++;
      if (n > 200) begin
        fail_now(name);
        return;
      end
      @(negedge clk);
    end
  endtask

  // Consumer
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor
  initial begin
    logic               prev_v;
    logic               prev_hs;
    logic [LANES*8-1:0] held;
    exp_t               e;
    prev_v  = 1'b0;
    prev_hs = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v  = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) chk("valid_drop", out_valid, 0);
        if (out_valid && !prev_v) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got out_pix %h required no output", out_pix);
          end else begin
            e = sb.pop_front();
            n_out++;
            $display("block %0d cyc %0d out_pix=%h err_len=%0b", n_out, cyc, out_pix, err_len);
            chk("out_pix", out_pix, e.pix);
            chk("err_len", err_len, e.err);
            chk("latency", cyc, e.cyc);
          end
          held = out_pix;
        end else begin
          if (out_valid) chk("hold_stable", out_pix, held);
          if (err_len) chk("stray_err", err_len, 0);
        end
        if (out_valid) chk("hold_in_ready", in_ready, 0);
        prev_v  = out_valid;
        prev_hs = out_valid && out_ready;
      end
    end
  end

  // Watchdog
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bit lst;
    int n;
    // Reset state
    do_reset();
    @(posedge clk);
    #1;

    // All +1, base 100 -> 104
    ready_mode = 2;
    fill(1);
    set_over(104);
    send_block(BEATS, 1, 100, 0, 1);

    // Clamp both directions
    fill(0);
    for (int b = 0; b < BEATS; b++) begin
      blk[b][0] = -128;
      blk[b][1] = 127;
    end
    set_over(0);
    exp_over[1] = 255;
    send_block(BEATS, 1, 0, 0, 1);

    // Short block: 3 beats of 4, base 10 -> 13 with length error
    fill(4);
    set_over(13);
    send_block(3, 1, 10, 0, 1);
    // Full block with no last -> length error, still closes
    fill(0);
    set_over(10);
    send_block(BEATS, 0, 10, 0, 1);

    // Rounding: +2 -> 51, -3 -> 49
    fill(0);
    blk[0][0] = 2;
    blk[0][1] = -3;
    set_over(50);
    exp_over[0] = 51;
    exp_over[1] = 49;
    send_block(BEATS, 1, 50, 0, 1);

    // Back-pressure: consumer stalls 5 cycles while the next block waits
    ready_mode = 1;
    fill(1);
    fork
      begin
        send_block(BEATS, 1, 100, 0, 0);
        fill(2);
        send_block(BEATS, 1, 20, 0, 0);
      end
      begin
        @(negedge clk);
        wait_valid("stall_valid");
        repeat (5) @(posedge clk);
        ready_mode = 2;
      end
    join

    // Reset mid-block, then a fresh zero block with base 77
    ready_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    fill(1);
    send_block(8, 0, 33, 0, 0);
    do_reset();
    repeat (3) @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    fill(0);
    set_over(77);
    send_block(BEATS, 1, 77, 0, 1);

    // Reset while holding a result
    ready_mode = 1;
    fill(3);
    send_block(BEATS, 1, 60, 0, 0);
    @(negedge clk);
    wait_valid("hold_valid");
    @(posedge clk);
    #1;
    do_reset();
    repeat (4) @(negedge clk);
    chk("hold_rst_valid", out_valid, 0);
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Randomised blocks
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(1, BEATS);
      lst = (len < BEATS) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int b = 0; b < BEATS; b++)
        for (int l = 0; l < LANES; l++)
          blk[b][l] = (k % 4 == 0) ? ((l % 2 == 0) ? -128 : 127)
                                   : int'($urandom_range(0, 255)) - 128;
      send_block(len, lst, $urandom_range(0, 255), 1, 0);
    end

    // Drain
    ready_mode = 2;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail_now("drain");
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
